// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encodings, operand-length
// codes and the default reset-vector address.
package fetch_unit_pkg;

   // Fetch sequencer states: three reset-vector steps, then the per-instruction loop
   typedef enum logic [2:0] {
      ST_V0  = 3'd0,
      ST_V1  = 3'd1,
      ST_V2  = 3'd2,
      ST_OP  = 3'd3,
      ST_B0  = 3'd4,
      ST_B1  = 3'd5,
      ST_B2  = 3'd6,
      ST_RDY = 3'd7
   } fetch_state_t;

   // Number of operand bytes following an opcode
   localparam logic [1:0] LEN_0 = 2'd0;
   localparam logic [1:0] LEN_1 = 2'd1;
   localparam logic [1:0] LEN_2 = 2'd2;

   // Address of the reset-vector low byte; the high byte follows it
   localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/fetch_unit_opcode_length.sv
// Combinational operand-length decode for a 6502 opcode (aaa bbb cc).
// The cc=11 column holds no documented instruction and is flagged illegal.
module opcode_length
   import fetch_unit_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len,
   output logic       illegal
);

   logic [2:0] aaa;
   logic [2:0] bbb;
   logic [1:0] cc;

   assign aaa = opcode[7:5];
   assign bbb = opcode[4:2];
   assign cc  = opcode[1:0];

   // Map the addressing-mode field of each opcode group to its operand count
   always_comb begin
      len     = LEN_0;
      illegal = 1'b0;
      case (cc)
         2'b01: begin
            if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = LEN_2;
            else                                                 len = LEN_1;
         end
         2'b10: begin
            if (bbb == 3'b011 || bbb == 3'b111)                       len = LEN_2;
            else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101) len = LEN_1;
            else                                                      len = LEN_0;
         end
         2'b00: begin
            if (bbb == 3'b011 || bbb == 3'b111)                       len = LEN_2;
            else if (bbb == 3'b001 || bbb == 3'b100 || bbb == 3'b101) len = LEN_1;
            else if (bbb == 3'b000) begin
               // JSR carries an absolute target; LDY/CPY/CPX immediate carry one byte
               if (aaa == 3'b001)                                        len = LEN_2;
               else if (aaa == 3'b101 || aaa == 3'b110 || aaa == 3'b111) len = LEN_1;
               else                                                      len = LEN_0;
            end
            else len = LEN_0;
         end
         default: begin
            len     = LEN_0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the 6502 decoder. Loads the PC from the
// reset vector, then fetches opcode plus 0-2 operand bytes per instruction.
//
// Decoder handshake: instruction_ready is a level that is high only in the
// ready state, while instruction/addr/illegal are held stable. The decoder
// completes the transfer by raising instruction_done in a cycle where
// instruction_ready is high; done in any other cycle has no effect. pc_load
// is only honoured together with that completing done. The cycle after the
// transfer always drives instruction_ready low, so every new instruction is
// presented with a fresh rising edge.
//
// Memory reads: an address is issued with mem_rd_en in one cycle and the
// byte is expected on mem_data_in during the following cycle.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    REG_WIDTH    = 8,
   parameter int                    ADDR_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [REG_WIDTH-1:0]  mem_data_in,
   output logic [REG_WIDTH-1:0]  instruction,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  instruction_ready,
   input  logic                  instruction_done,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  illegal
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [REG_WIDTH-1:0]  vec_lo;
   logic [1:0]            len_q;
   logic [1:0]            dec_len;
   logic                  dec_illegal;

   // Length decode looks at the byte arriving in B0, which is the opcode
   opcode_length u_opcode_length (
      .opcode  (mem_data_in),
      .len     (dec_len),
      .illegal (dec_illegal)
   );

   assign pc_out = pc;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_V0;
      else       state <= state_next;
   end

   // Next-state logic and per-state memory request / ready strobe
   always_comb begin
      state_next        = state;
      mem_addr          = '0;
      mem_rd_en         = 1'b0;
      instruction_ready = 1'b0;
      case (state)
         ST_V0: begin
            mem_addr   = RESET_VECTOR;
            mem_rd_en  = 1'b1;
            state_next = ST_V1;
         end
         ST_V1: begin
            mem_addr   = RESET_VECTOR + ONE;
            mem_rd_en  = 1'b1;
            state_next = ST_V2;
         end
         ST_V2: state_next = ST_OP;
         ST_OP: begin
            mem_addr   = pc;
            mem_rd_en  = 1'b1;
            state_next = ST_B0;
         end
         ST_B0: begin
            if (dec_len != LEN_0) begin
               mem_addr   = pc;
               mem_rd_en  = 1'b1;
               state_next = ST_B1;
            end
            else state_next = ST_RDY;
         end
         ST_B1: begin
            if (len_q == LEN_2) begin
               mem_addr   = pc;
               mem_rd_en  = 1'b1;
               state_next = ST_B2;
            end
            else state_next = ST_RDY;
         end
         ST_B2: state_next = ST_RDY;
         ST_RDY: begin
            instruction_ready = 1'b1;
            if (instruction_done) state_next = ST_OP;
         end
         default: state_next = ST_V0;
      endcase
   end

   // Datapath: capture returning bytes and advance the PC once per issued read
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= '0;
         vec_lo      <= '0;
         len_q       <= LEN_0;
         instruction <= '0;
         addr        <= '0;
         illegal     <= 1'b0;
      end
      else begin
         case (state)
            ST_V1: vec_lo <= mem_data_in;
            ST_V2: pc     <= {mem_data_in, vec_lo};
            ST_OP: pc     <= pc + ONE;
            ST_B0: begin
               instruction <= mem_data_in;
               len_q       <= dec_len;
               illegal     <= dec_illegal;
               addr        <= '0;
               if (dec_len != LEN_0) pc <= pc + ONE;
            end
            ST_B1: begin
               addr <= {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, mem_data_in};
               if (len_q == LEN_2) pc <= pc + ONE;
            end
            ST_B2: addr <= {mem_data_in, addr[REG_WIDTH-1:0]};
            ST_RDY: begin
               // A jump replaces the sequential PC only when the decoder retires the instruction
               if (instruction_done && pc_load) pc <= pc_in;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a byte-array memory with one-cycle
// read latency, directed scenarios and randomized instruction streams with
// random jumps, checked against an instruction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data_in;
  logic [7:0]  instruction;
  logic [15:0] addr;
  logic        instruction_ready;
  logic        instruction_done;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] pc_out;
  logic        illegal;

  logic [7:0]  mem [0:65535];
  logic [40:0] exp_q[$];   // {illegal, pc_after, operand, opcode}
  logic [15:0] mpc;        // model PC: address of the next opcode
  int          checks = 0;
  int          errors = 0;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr          (mem_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_data_in       (mem_data_in),
    .instruction       (instruction),
    .addr              (addr),
    .instruction_ready (instruction_ready),
    .instruction_done  (instruction_done),
    .pc_load           (pc_load),
    .pc_in             (pc_in),
    .pc_out            (pc_out),
    .illegal           (illegal)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous memory: data for an address issued this cycle appears next cycle
  always @(posedge clk) begin
    if (mem_rd_en) mem_data_in <= mem[mem_addr];
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Operand-byte count straight from the opcode-group rules
  function automatic int ref_len(input logic [7:0] op);
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] c;
    a = op[7:5];
    b = op[4:2];
    c = op[1:0];
    if (c == 2'b11) return 0;
    if (b == 3'd3 || b == 3'd7) return 2;
    if (c == 2'b01) return (b == 3'd6) ? 2 : 1;
    if (c == 2'b10) return (b inside {3'd0, 3'd1, 3'd5}) ? 1 : 0;
    if (b inside {3'd1, 3'd4, 3'd5}) return 1;
    if (b == 3'd0) begin
      if (a == 3'd1) return 2;
      if (a inside {3'd5, 3'd6, 3'd7}) return 1;
    end
    return 0;
  endfunction

  // Assert reset for n cycles, check reset state, then walk the vector fetch to the first OP cycle
  task automatic do_reset(input int n);
    reset = 1'b1;
    instruction_done = 1'b0;
    pc_load = 1'b0;
    pc_in = 16'h0;
    repeat (n) @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_ready", 32'(instruction_ready), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("v0_addr", 32'(mem_addr), 32'hFFFC);
    check("v0_rd_en", 32'(mem_rd_en), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("v1_addr", 32'(mem_addr), 32'hFFFD);
    check("v1_rd_en", 32'(mem_rd_en), 32'h1);
    @(negedge clk);
    check("v2_rd_en", 32'(mem_rd_en), 32'h0);
    @(negedge clk);
    mpc = {mem[16'hFFFD], mem[16'hFFFC]};
  endtask

  // Entered at the negedge of an OP cycle; leaves at the negedge of the next OP cycle.
  // hold < 0 picks a random number of ready cycles before done.
  task automatic run_instr(input bit do_load, input logic [15:0] target, input int hold);
    int          len;
    int          lat;
    int          reads;
    int          h;
    logic [7:0]  op;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] ea;
    logic [15:0] next_pc;
    logic [40:0] e;
    check("op_addr", 32'(mem_addr), 32'(mpc));
    check("op_rd_en", 32'(mem_rd_en), 32'h1);
    check("op_ready_low", 32'(instruction_ready), 32'h0);
    check("op_pc", 32'(pc_out), 32'(mpc));
    op = mem[mpc];
    len = ref_len(op);
    a1 = mpc + 16'd1;
    a2 = mpc + 16'd2;
    next_pc = mpc + 16'(1 + len);
    ea = (len == 2) ? {mem[a2], mem[a1]} : (len == 1) ? {8'h00, mem[a1]} : 16'h0000;
    exp_q.push_back({(op[1:0] == 2'b11), next_pc, ea, op});
    lat = 0;
    reads = 0;
    while (!instruction_ready && lat < 10) begin
      if (mem_rd_en) reads++;
      instruction_done = 1'($urandom_range(0, 1));
      pc_load = 1'($urandom_range(0, 1));
      pc_in = 16'($urandom);
      @(negedge clk);
      lat++;
      if (lat == 1) check("pc_after_op", 32'(pc_out), 32'(a1));
    end
    instruction_done = 1'b0;
    pc_load = 1'b0;
    check("ready", 32'(instruction_ready), 32'h1);
    check("latency", lat, 2 + len);
    check("reads", reads, 1 + len);
    check("rdy_rd_en", 32'(mem_rd_en), 32'h0);
    e = exp_q.pop_front();
    check("instruction", 32'(instruction), 32'(e[7:0]));
    check("operand", 32'(addr), 32'(e[23:8]));
    check("pc_rdy", 32'(pc_out), 32'(e[39:24]));
    check("illegal", 32'(illegal), 32'(e[40]));
    h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
    for (int i = 0; i < h; i++) begin
      pc_load = 1'($urandom_range(0, 1));
      pc_in = 16'($urandom);
      @(negedge clk);
      check("hold_ready", 32'(instruction_ready), 32'h1);
      check("hold_operand", 32'(addr), 32'(e[23:8]));
      check("hold_instr", 32'(instruction), 32'(e[7:0]));
    end
    instruction_done = 1'b1;
    pc_load = do_load;
    pc_in = target;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    mpc = do_load ? target : next_pc;
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    instruction_done = 1'b0;
    pc_load = 1'b0;
    pc_in = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    mem[16'h8005] = 8'h0A;
    mem[16'h8006] = 8'h6B;
    mem[16'hFFFF] = 8'h4C;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'hA9; mem[16'h0003] = 8'h55;

    do_reset(2);
    run_instr(1'b0, 16'h0, 0);         // A9 42
    run_instr(1'b0, 16'h0, 5);         // 8D 00 02, decoder stalls
    run_instr(1'b0, 16'h0, -1);        // 0A
    run_instr(1'b1, 16'h9000, -1);     // 6B illegal, then jump
    check("jump_target", 32'(mpc), 32'h9000);

    for (int n = 0; n < 150; n++)
      run_instr(($urandom_range(0, 3) == 0), 16'($urandom), -1);

    run_instr(1'b1, 16'hFFFF, -1);
    run_instr(1'b0, 16'h0, 0);         // 4C at FFFF, operands wrap to 0000/0001
    check("wrap_pc", 32'(mpc), 32'h0002);

    // Reset in the middle of fetching A9 at 0002
    check("mf_op_addr", 32'(mem_addr), 32'h0002);
    @(negedge clk);
    @(negedge clk);
    check("mf_b1_pc", 32'(pc_out), 32'h0004);
    pc_load = 1'b1;
    pc_in = 16'h1234;
    do_reset(1);
    run_instr(1'b0, 16'h0, -1);
    run_instr(1'b0, 16'h0, -1);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
